// File: rtl/fdiv_generic.sv
// Iterative floating-point divider: restoring radix-2 mantissa division, then RNE rounding.
// Flush-to-zero inputs, saturating overflow, single exception flag; fixed latency mantbits+7.
module fdiv_generic #(
  parameter int fbits   = 32,
  parameter int expbits = 8
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_ena,
  input  logic [fbits-1:0] i_a,
  input  logic [fbits-1:0] i_b,
  output logic             o_ready,
  output logic [fbits-1:0] o_res,
  output logic             o_ex,
  output logic             o_valid
);
  localparam int MB = fbits - expbits - 1;
  localparam int EW = expbits + 2;
  localparam int QW = MB + 3;
  localparam int RW = MB + 2;
  localparam int CW = $clog2(MB + 3);
  localparam logic [EW-1:0] BIAS     = EW'((1 << (expbits - 1)) - 1);
  localparam logic [EW-1:0] EMAX     = EW'((1 << expbits) - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MB + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_DIV, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [fbits-1:0] r_a, r_b;
  logic             r_sign, r_za, r_zb;
  logic [EW-1:0]    r_e;
  logic [MB:0]      r_mb;
  logic [RW-1:0]    r_rem;
  logic [QW-1:0]    r_q;
  logic [CW-1:0]    r_cnt;
  logic [MB-1:0]    r_frac;
  logic             r_guard, r_sticky;

  logic             w_ge;
  logic [RW-1:0]    w_diff, w_rem_nxt;
  logic             w_inc, w_carry, w_ovf, w_unf, w_ex;
  logic [MB:0]      w_fsum;
  logic [EW-1:0]    w_e_rnd;
  logic [fbits-1:0] w_res;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_ena) w_next = S_UNPACK;
      S_UNPACK: w_next = S_DIV;
      S_DIV:    if (r_cnt == CNT_LAST) w_next = S_NORM;
      S_NORM:   w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE);

  // One restoring step: the remainder always stays below 2*mb, so the shift drops nothing.
  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_diff    = r_rem - {1'b0, r_mb};
  assign w_rem_nxt = w_ge ? w_diff : r_rem;

  // The hidden bit is always 1, so a carry out of the fraction field is a significand overflow.
  assign w_inc   = r_guard & (r_sticky | r_frac[0]);
  assign w_fsum  = {1'b0, r_frac} + {{MB{1'b0}}, w_inc};
  assign w_carry = w_fsum[MB];
  assign w_e_rnd = r_e + {{(EW-1){1'b0}}, w_carry};
  assign w_ovf   = !w_e_rnd[EW-1] && (w_e_rnd >= EMAX);
  assign w_unf   = w_e_rnd[EW-1] || (w_e_rnd == '0);

  always_comb begin
    w_res = '0;
    w_ex  = 1'b0;
    if (r_zb) begin
      w_res = {r_sign, {(fbits-1){1'b1}}};
      w_ex  = 1'b1;
    end else if (r_za) begin
      w_res = {r_sign, {(fbits-1){1'b0}}};
    end else if (w_ovf) begin
      w_res = {r_sign, {(fbits-1){1'b1}}};
      w_ex  = 1'b1;
    end else if (w_unf) begin
      w_res = {r_sign, {(fbits-1){1'b0}}};
      w_ex  = 1'b1;
    end else begin
      w_res = {r_sign, w_e_rnd[expbits-1:0], w_fsum[MB-1:0]};
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sign   <= 1'b0;
      r_za     <= 1'b0;
      r_zb     <= 1'b0;
      r_e      <= '0;
      r_mb     <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_frac   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      o_res    <= '0;
      o_ex     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_ena) begin
            r_a <= i_a;
            r_b <= i_b;
          end
        end
        S_UNPACK: begin
          r_sign <= r_a[fbits-1] ^ r_b[fbits-1];
          r_e    <= {2'b00, r_a[fbits-2:MB]} - {2'b00, r_b[fbits-2:MB]} + BIAS;
          r_za   <= (r_a[fbits-2:MB] == '0);
          r_zb   <= (r_b[fbits-2:MB] == '0);
          r_rem  <= {2'b01, r_a[MB-1:0]};
          r_mb   <= {1'b1, r_b[MB-1:0]};
          r_q    <= '0;
          r_cnt  <= '0;
        end
        S_DIV: begin
          r_rem <= w_rem_nxt << 1;
          r_q   <= {r_q[QW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_NORM: begin
          if (r_q[QW-1]) begin
            r_frac   <= r_q[QW-2:2];
            r_guard  <= r_q[1];
            r_sticky <= (r_rem != '0) | r_q[0];
          end else begin
            r_frac   <= r_q[QW-3:1];
            r_guard  <= r_q[0];
            r_sticky <= (r_rem != '0);
            r_e      <= r_e - EW'(1);
          end
        end
        S_ROUND: begin
          o_res <= w_res;
          o_ex  <= w_ex;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_generic.sv
// Directed and randomised checks of fdiv_generic in its FP32 configuration.
module tb_fdiv_generic;
  localparam int LAT = 30;

  logic        i_clk, i_nrst, i_ena;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_ex, o_valid;
  logic [31:0] o_res;

  int n_cmp = 0;
  int n_err = 0;

  fdiv_generic #(.fbits(32), .expbits(8)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_ena(i_ena),
    .i_a(i_a), .i_b(i_b),
    .o_ready(o_ready), .o_res(o_res), .o_ex(o_ex), .o_valid(o_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic real f2d(input logic [31:0] f);
    logic [10:0] e64;
    e64 = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e64, f[22:0], 29'd0});
  endfunction

  // Double quotient of two FP32 values is exact enough that rounding it to FP32 is correct RNE.
  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [23:0] sum;
    logic        g, s;
    int          e;
    d   = $realtobits(f2d(a) / f2d(b));
    e   = int'(d[62:52]) - 1023 + 127;
    g   = d[28];
    s   = |d[27:0];
    sum = {1'b0, d[51:29]} + {23'd0, g & (s | d[29])};
    if (sum[23]) e++;
    return {d[63], e[7:0], sum[22:0]};
  endfunction

  // Issue one op at a negedge and follow it to its o_valid cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ex);
    int lat;
    check({tag, " ready"}, 64'(o_ready), 64'd1);
    i_a = a; i_b = b; i_ena = 1'b1;
    @(negedge i_clk);
    i_ena = 1'b0;
    i_a = $urandom; i_b = $urandom;
    lat = 1;
    check({tag, " busy"}, 64'(o_ready), 64'd0);
    while (!o_valid && lat < 100) begin
      @(negedge i_clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " res"}, 64'(o_res), 64'(exp_res));
    check({tag, " ex"}, 64'(o_ex), 64'(exp_ex));
    @(negedge i_clk);
    check({tag, " valid drop"}, 64'(o_valid), 64'd0);
    check({tag, " hold"}, 64'(o_res), 64'(exp_res));
  endtask

  logic [31:0] vec_a   [7] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                               32'h00000000, 32'h7F000000, 32'h00800000};
  logic [31:0] vec_b   [7] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000,
                               32'h40A00000, 32'h3E800000, 32'h40000000};
  logic [31:0] vec_res [7] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'hFFFFFFFF,
                               32'h00000000, 32'h7FFFFFFF, 32'h00000000};
  logic        vec_ex  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0 | 1'b1};

  initial begin
    int          nv, v1, v2, seen;
    logic [31:0] r1, r2, ra, rb;
    logic [7:0]  ea, eb;

    i_nrst = 1'b0; i_ena = 1'b0; i_a = '0; i_b = '0;
    repeat (3) @(negedge i_clk);
    check("rst ready", 64'(o_ready), 64'd1);
    check("rst valid", 64'(o_valid), 64'd0);
    check("rst res", 64'(o_res), 64'd0);
    check("rst ex", 64'(o_ex), 64'd0);
    i_nrst = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vec_a[i], vec_b[i], vec_res[i], vec_ex[i]);

    // i_ena held high: the second accept can only happen once the divider is idle again.
    i_a = 32'h40C00000; i_b = 32'h40000000; i_ena = 1'b1;
    nv = 0; v1 = 0; v2 = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge i_clk);
      if (c == 1) begin i_a = 32'h3F800000; i_b = 32'h3F800000; end
      if (c == 32) i_ena = 1'b0;
      if (o_valid) begin
        nv++;
        if (nv == 1) begin v1 = c; r1 = o_res; end
        else begin v2 = c; r2 = o_res; end
      end
    end
    check("b2b count", 64'(nv), 64'd2);
    check("b2b first cycle", 64'(v1), 64'd30);
    check("b2b first res", 64'(r1), 64'h40400000);
    check("b2b second cycle", 64'(v2), 64'd61);
    check("b2b second res", 64'(r2), 64'h3F800000);

    for (int i = 0; i < 20; i++) begin
      ea = 8'($urandom_range(70, 180));
      eb = 8'($urandom_range(70, 180));
      ra = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), eb, 23'($urandom)};
      run_op($sformatf("rnd%0d %h/%h", i, ra, rb), ra, rb, model_div(ra, rb), 1'b0);
    end

    // Abort an operation at cycle 10 with reset.
    i_a = 32'h40C00000; i_b = 32'h40000000; i_ena = 1'b1;
    @(negedge i_clk);
    i_ena = 1'b0;
    repeat (9) @(negedge i_clk);
    i_nrst = 1'b0;
    #1;
    check("abort ready", 64'(o_ready), 64'd1);
    check("abort valid", 64'(o_valid), 64'd0);
    check("abort res", 64'(o_res), 64'd0);
    check("abort ex", 64'(o_ex), 64'd0);
    repeat (2) @(negedge i_clk);
    i_nrst = 1'b1;
    seen = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    check("abort no valid", 64'(seen), 64'd0);
    run_op("after abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
